block_serial_cla_adder: RTL

//  Sequential consumer of block generate/propagate signals. Adds two WIDTH-bit operands
//  one VALENCY-bit block per cycle:
//  - forms per-bit g/p and group GG/GP for the current block;
//  - resolves the block carry-out as GG | (GP & carry);
//  - produces the block sum bits.

---
 rtl/block_serial_cla_adder_pkg.sv | 19 +
 rtl/block_serial_cla_adder_grp_gp_cell.sv | 30 +++
 rtl/block_serial_cla_adder.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/block_serial_cla_adder_pkg.sv
// Shared definitions for the block-serial carry-lookahead adder.
// Latency: n/a (types and helper function only).
// Backpressure: n/a.
// Contents: FSM state encoding and the block-index width helper.
package block_serial_cla_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Width of the block index counter; never narrower than one bit so a
  // single-block configuration still has a legal vector.
  function automatic int blk_idx_w(input int nblk);
    return (nblk > 1) ? $clog2(nblk) : 1;
  endfunction

endpackage

// File: rtl/block_serial_cla_adder_grp_gp_cell.sv
// Group generate/propagate tree for one VALENCY-bit block.
// Latency: combinational.
// Backpressure: none (pure logic).
// Ports: g_i/p_i per-bit generate/propagate, gg_o/gp_o group generate/propagate.
module grp_gp_cell #(
  parameter int VALENCY = 4
) (
  input  logic [VALENCY-1:0] g_i,
  input  logic [VALENCY-1:0] p_i,
  output logic               gg_o,
  output logic               gp_o
);

  logic gg_acc;
  logic gp_acc;

  // Prefix recurrence from the block LSB upward.
  always_comb begin
    gg_acc = g_i[0];
    gp_acc = p_i[0];
    for (int j = 1; j < VALENCY; j++) begin
      gg_acc = g_i[j] | (p_i[j] & gg_acc);
      gp_acc = p_i[j] & gp_acc;
    end
  end

  assign gg_o = gg_acc;
  assign gp_o = gp_acc;

endmodule

// File: rtl/block_serial_cla_adder.sv
// Sequential adder: processes one VALENCY-bit block of a+b+cin per cycle.
// Latency: accept at edge T, out_valid from edge T+NBLK.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready + a, b, cin operand
//        handshake; out_valid/out_ready + sum, cout result handshake.
module block_serial_cla_adder
  import block_serial_cla_adder_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int VALENCY     = 4,
  parameter int APPROX_BLKS = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NBLK  = WIDTH / VALENCY;
  localparam int IDXW  = blk_idx_w(NBLK);
  localparam int NSLOT = 1 << IDXW;
  localparam logic [IDXW-1:0] LAST_BLK = IDXW'(NBLK - 1);

  // One flag per index value (padded to the full index range) marking the
  // low blocks that are computed approximately.
  function automatic logic [NSLOT-1:0] approx_mask_f(input int nappr);
    logic [NSLOT-1:0] m;
    m = '0;
    for (int i = 0; i < NSLOT; i++) begin
      m[i] = (i < nappr);
    end
    return m;
  endfunction

  localparam logic [NSLOT-1:0] APPROX_MASK = approx_mask_f(APPROX_BLKS);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic [IDXW-1:0]   k_q, k_d;

  logic [VALENCY-1:0] blk_a;
  logic [VALENCY-1:0] blk_b;
  logic [VALENCY-1:0] blk_g;
  logic [VALENCY-1:0] blk_p;
  logic [VALENCY-1:0] blk_c;
  logic [VALENCY-1:0] exact_sum;
  logic [VALENCY-1:0] blk_sum;
  logic               exact_carry;
  logic               blk_carry;
  logic               blk_approx;
  logic               grp_gg;
  logic               grp_gp;

  // Current block operands and per-bit generate/propagate.
  always_comb begin
    blk_a = a_q[k_q*VALENCY +: VALENCY];
    blk_b = b_q[k_q*VALENCY +: VALENCY];
    blk_g = blk_a & blk_b;
    blk_p = blk_a ^ blk_b;
  end

  grp_gp_cell #(
    .VALENCY (VALENCY)
  ) u_grp_gp_cell (
    .g_i  (blk_g),
    .p_i  (blk_p),
    .gg_o (grp_gg),
    .gp_o (grp_gp)
  );

  // Bit carries ripple inside the block; the block carry-out comes from the
  // group cell rather than the top of the ripple chain.
  always_comb begin
    blk_c    = '0;
    blk_c[0] = carry_q;
    for (int i = 1; i < VALENCY; i++) begin
      blk_c[i] = blk_g[i-1] | (blk_p[i-1] & blk_c[i-1]);
    end
    exact_sum   = blk_p ^ blk_c;
    exact_carry = grp_gg | (grp_gp & carry_q);

    blk_approx = APPROX_MASK[k_q];
    if (blk_approx) begin
      blk_sum   = blk_a | blk_b;
      blk_carry = 1'b0;
    end else begin
      blk_sum   = exact_sum;
      blk_carry = exact_carry;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    k_d     = k_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          k_d     = '0;
          // With approximate low blocks the first exact block starts at 0.
          carry_d = (APPROX_BLKS > 0) ? 1'b0 : cin;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[k_q*VALENCY +: VALENCY] = blk_sum;
        carry_d = blk_carry;
        if (k_q == LAST_BLK) begin
          cout_d  = blk_carry;
          state_d = ST_DONE;
        end else begin
          k_d = k_q + IDXW'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      k_q     <= k_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule
